lcd_serial_shifter: RTL and testbench
=====================================

// Module: lcd_serial_shifter
// PURPOSE
//  Avalon-MM slave that serialises LCD command/data words onto a 3-wire bus (cs_n, sclk, si) plus a0.
//  Parametrised successor to the single-bit LCD_SI PIO: the hardware clocks out full words.
//  Programmable clock divider, busy/done/overrun status.
//  Sits on the CPU data master beside the other PIO slaves; zero-wait-state reads.
// PARAMETERS
//  DATA_W       8   bits per transfer, MSB first (1..31)
//  DIV_W        16  width of the clock-divider field
//  DEFAULT_DIV  4   reset value of CTRL.div
// PORTS
//  clk        in   1       system clock; single clock domain
//  reset      in   1       synchronous, active-high reset
//  address    in   2       register select
//  chipselect in   1       slave select
//  write_n    in   1       active-low write strobe
//  writedata  in   32      write data
//  readdata   out  32      read data; combinational from address, unused bits 0
//  lcd_cs_n   out  1       LCD chip select, active low
//  lcd_sclk   out  1       serial clock, idles low
//  lcd_si     out  1       serial data
//  lcd_a0     out  1       command(0)/data(1) select
//  irq        out  1       present only with LCD_SHIFTER_IRQ_EN
// BEHAVIOUR
//  Write = chipselect & ~write_n.
//  Register map:
//   0 DATA  : W [DATA_W-1:0]=word, [DATA_W]=a0.  R: last word written.
//   1 STATUS: R bit0 busy, bit1 done, bit2 overrun.  W1C on bits 1,2.
//   2 CTRL  : RW [DIV_W-1:0] div, [31] irq_en.
//   3 —     : reads 0, writes ignored.
//  Reset values:
//   - cs_n=1, sclk=0, si=0, a0=0, busy=0, done=0, overrun=0.
//   - div=DEFAULT_DIV, irq_en=0, DATA=0, irq=0.
//  Half period H = div+1 clk cycles. div is latched at transfer start.
//  A CTRL write during busy affects the next transfer only.
//  FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE:
//   IDLE : DATA write at edge N loads shifter and a0. At N+1: state=SETUP, busy=1, cs_n=0, si=MSB.
//   SETUP: H cycles, sclk=0.
//   SHIFT: per bit, sclk=1 for H cycles then sclk=0 for H cycles.
//          si advances to the next bit on the falling edge (SPI mode 0).
//          The low phase of the last bit is the HOLD state.
//   HOLD : on exit cs_n=1, busy=0, done=1, si=0; a0 keeps its value.
//  busy lasts exactly H*(1+2*DATA_W) cycles. Exactly DATA_W rising sclk edges per transfer.
//  DATA write while busy: word dropped, overrun=1, transfer unaffected.
//  STATUS W1C in the same cycle as a done/overrun set event: the set wins.
//  div=0 is legal: H=1, sclk toggles every cycle.
//  Reset mid-transfer: immediate return to reset values next edge; no partial completion, done stays 0.
//  DATA readback updates even on overrun (the dropped word is shown).
// CONFIGURATION
//  LCD_SHIFTER_IRQ_EN defined:
//   - irq port exists; irq = irq_en & done (registered, level).
//   - Cleared by W1C of done.
//  Not defined:
//   - no irq port; CTRL[31] reads 0 and ignores writes.
// TESTING
//  1 Reset -> cs_n=1, sclk=0, si=0, a0=0, STATUS=0, CTRL=0x0004.
//  2 CTRL=1, DATA=0x1A5 -> a0=1; si sampled at 8 rising sclk edges = 1,0,1,0,0,1,0,1;
//    busy high 34 cycles; then STATUS=0x2.
//  3 Second DATA write 5 cycles into a transfer -> STATUS bit2=1;
//    first word completes unchanged; W1C 0x6 -> STATUS=0.
//  4 CTRL=0, DATA=0x0FF -> sclk toggles every cycle; busy 17 cycles; a0=0.
//  5 Assert reset 10 cycles into a transfer -> next edge cs_n=1, sclk=0, busy=0, done=0.
//  6 (IRQ_EN) CTRL=0x80000001, transfer -> irq rises with done;
//    W1C 0x2 in the completion cycle -> done and irq stay 1.

Source files
------------

// File: rtl/lcd_serial_shifter.sv
// Avalon-MM slave that shifts LCD command/data words out MSB first on cs_n/sclk/si plus a0.
// Optional LCD_SHIFTER_IRQ_EN adds a level irq output and the CTRL[31] irq_en bit.
module lcd_serial_shifter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_cs_n,
  output logic        lcd_sclk,
  output logic        lcd_si,
  output logic        lcd_a0
`ifdef LCD_SHIFTER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned BW = 5;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_div_lat;
  logic [DIV_W-1:0]    r_cnt;
  logic [BW-1:0]       r_bits;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   w_shifted;
  logic [DATA_W:0]     r_data;
  logic                r_cs_n;
  logic                r_sclk;
  logic                r_si;
  logic                r_a0;
  logic                r_done;
  logic                r_ovr;
  logic                w_done_nxt;
  logic                w_wr;
  logic                w_wr_data;
  logic                w_wr_stat;
  logic                w_wr_ctrl;
  logic                w_start;
  logic                w_tick;
  logic                w_busy;
  logic                w_done_set;
  logic                w_ovr_set;
  logic                w_unused;

`ifdef LCD_SHIFTER_IRQ_EN
  logic                r_irq_en;
  logic                r_irq;
  assign irq = r_irq;
`endif

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_data = w_wr && (address == 2'd0);
  assign w_wr_stat = w_wr && (address == 2'd1);
  assign w_wr_ctrl = w_wr && (address == 2'd2);
  assign w_shifted = r_shreg << 1;
  assign w_unused  = &{1'b0, writedata};

  assign lcd_cs_n = r_cs_n;
  assign lcd_sclk = r_sclk;
  assign lcd_si   = r_si;
  assign lcd_a0   = r_a0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_SETUP;
      S_SETUP: if (w_tick) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_tick && r_sclk && (r_bits == '0)) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tick) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_tick     = (r_cnt == '0);
    w_start    = w_wr_data && !w_busy;
    w_ovr_set  = w_wr_data && w_busy;
    w_done_set = (r_state == S_HOLD) && w_tick;
    w_done_nxt = w_done_set | (r_done & ~(w_wr_stat & writedata[1]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_div_lat <= '0;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_si      <= 1'b0;
      r_a0      <= 1'b0;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef LCD_SHIFTER_IRQ_EN
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
`endif
    end else begin
      if (w_wr_ctrl) begin
        r_div <= writedata[DIV_W-1:0];
`ifdef LCD_SHIFTER_IRQ_EN
        r_irq_en <= writedata[31];
`endif
      end
      if (w_wr_data) r_data <= writedata[DATA_W:0];
      r_done <= w_done_nxt;
      r_ovr  <= w_ovr_set | (r_ovr & ~(w_wr_stat & writedata[2]));
`ifdef LCD_SHIFTER_IRQ_EN
      r_irq  <= r_irq_en & w_done_nxt;
`endif

      // r_cnt counts a half period down to zero; each zero ends a phase
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_shreg   <= writedata[DATA_W-1:0];
          r_a0      <= writedata[DATA_W];
          r_si      <= writedata[DATA_W-1];
          r_cs_n    <= 1'b0;
          r_sclk    <= 1'b0;
          r_cnt     <= r_div;
          r_div_lat <= r_div;
        end
      end else if (w_tick) begin
        r_cnt <= r_div_lat;
        case (r_state)
          S_SETUP: begin
            r_sclk <= 1'b1;
            r_bits <= BW'(DATA_W - 1);
          end
          S_SHIFT: begin
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (r_bits != '0) begin
                r_shreg <= w_shifted;
                r_si    <= w_shifted[DATA_W-1];
              end
            end else begin
              r_sclk <= 1'b1;
              r_bits <= r_bits - BW'(1);
            end
          end
          S_HOLD: begin
            r_cs_n <= 1'b1;
            r_si   <= 1'b0;
          end
          default: ;
        endcase
      end else begin
        r_cnt <= r_cnt - DIV_W'(1);
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[DATA_W:0] = r_data;
      2'd1: readdata[2:0] = {r_ovr, r_done, w_busy};
      2'd2: begin
        readdata[DIV_W-1:0] = r_div;
`ifdef LCD_SHIFTER_IRQ_EN
        readdata[31] = r_irq_en;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_serial_shifter.sv
// Directed and random transfers for lcd_serial_shifter, checked against a transfer-level model.
module tb_lcd_serial_shifter;
  localparam int unsigned DW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        lcd_cs_n, lcd_sclk, lcd_si, lcd_a0;
`ifdef LCD_SHIFTER_IRQ_EN
  logic        irq;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int unsigned m_div  = 4;
  logic [8:0]  m_data = '0;
  logic        m_ovr  = 1'b0;

  lcd_serial_shifter #(.DATA_W(DW), .DIV_W(16), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .lcd_cs_n(lcd_cs_n), .lcd_sclk(lcd_sclk), .lcd_si(lcd_si), .lcd_a0(lcd_a0)
`ifdef LCD_SHIFTER_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic set_ctrl(input logic [31:0] d);
    logic [31:0] e;
    bus_wr(2'd2, d);
    m_div = int'(d[15:0]);
    e = {16'h0, d[15:0]};
`ifdef LCD_SHIFTER_IRQ_EN
    e[31] = d[31];
`endif
    chk_reg("ctrl_rb", 2'd2, e);
  endtask

  task automatic clear_status();
    bus_wr(2'd1, 32'h6);
    m_ovr = 1'b0;
    chk_reg("status_w1c", 2'd1, 32'h0);
  endtask

  // One transfer; optionally one extra bus write injected inj_at busy cycles in.
  task automatic run_xfer(input logic [7:0] word, input logic a0, input int unsigned inj_at,
                          input logic [1:0] inj_a, input logic [31:0] inj_d, input string tag);
    int unsigned h, exp_len, cnt, rises, csbad, guard;
    logic [7:0]  got;
    logic        prev_sclk, fin;
    logic [31:0] v;
    h = m_div + 1;
    exp_len = h * (1 + 2 * DW);
    cnt = 0; rises = 0; csbad = 0; guard = 0;
    got = '0; prev_sclk = 1'b0; fin = 1'b0;
    bus_wr(2'd0, {23'h0, a0, word});
    m_data = {a0, word};
    chk({tag, "_a0"}, {31'h0, lcd_a0}, {31'h0, a0});
    while (!fin && guard < 5000) begin
      guard++;
      if (lcd_sclk && !prev_sclk) begin
        got = {got[6:0], lcd_si};
        rises++;
      end
      prev_sclk = lcd_sclk;
      rd(2'd1, v);
      if (v[0]) begin
        cnt++;
        if (lcd_cs_n) csbad++;
        if (cnt == inj_at) begin
          address = inj_a; writedata = inj_d; chipselect = 1'b1; write_n = 1'b0;
          if (inj_a == 2'd0) begin m_ovr = 1'b1; m_data = inj_d[8:0]; end
          if (inj_a == 2'd2) m_div = int'(inj_d[15:0]);
        end
      end else begin
        fin = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
      end
    end
    chk({tag, "_finished"}, {31'h0, fin}, 32'h1);
    chk({tag, "_busy_len"}, cnt, exp_len);
    chk({tag, "_rises"}, rises, DW);
    chk({tag, "_bits"}, {24'h0, got}, {24'h0, word});
    chk({tag, "_cs_low"}, csbad, 0);
    chk({tag, "_end_pins"}, {28'h0, lcd_cs_n, lcd_sclk, lcd_si, lcd_a0}, {28'h0, 1'b1, 1'b0, 1'b0, a0});
    chk_reg({tag, "_status"}, 2'd1, {29'h0, m_ovr, 1'b1, 1'b0});
    chk_reg({tag, "_data_rb"}, 2'd0, {23'h0, m_data});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_pins", {28'h0, lcd_cs_n, lcd_sclk, lcd_si, lcd_a0}, 32'h8);
    chk_reg("rst_status", 2'd1, 32'h0);
    chk_reg("rst_ctrl", 2'd2, 32'h4);
    chk_reg("rst_data", 2'd0, 32'h0);
    chk_reg("reg3", 2'd3, 32'h0);
`ifdef LCD_SHIFTER_IRQ_EN
    chk("rst_irq", {31'h0, irq}, 32'h0);
`endif

    set_ctrl(32'h1);
    run_xfer(8'hA5, 1'b1, 0, 2'd0, 32'h0, "t2");
    clear_status();

    set_ctrl(32'h2);
    run_xfer(8'h3C, 1'b0, 5, 2'd0, 32'h1C3, "ovr");
    clear_status();

    run_xfer(8'h81, 1'b1, 3, 2'd2, 32'h0, "ctrl_mid");
    chk_reg("ctrl_mid_rb", 2'd2, 32'h0);
    clear_status();
    run_xfer(8'hFF, 1'b0, 0, 2'd0, 32'h0, "div0");
    clear_status();

`ifdef LCD_SHIFTER_IRQ_EN
    set_ctrl(32'h8000_0001);
    run_xfer(8'h5A, 1'b1, 34, 2'd1, 32'h2, "irq");
    chk("irq_set", {31'h0, irq}, 32'h1);
    clear_status();
    chk("irq_clr", {31'h0, irq}, 32'h0);
    set_ctrl(32'h1);
`else
    set_ctrl(32'h1);
    run_xfer(8'h5A, 1'b1, 34, 2'd1, 32'h2, "w1c_race");
    clear_status();
`endif

    repeat (6) begin
      set_ctrl({16'h0, 16'($urandom_range(0, 3))});
      run_xfer(8'($urandom), 1'($urandom), 0, 2'd0, 32'h0, "rand");
      clear_status();
    end

    set_ctrl(32'h3);
    bus_wr(2'd0, 32'h155);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pins", {28'h0, lcd_cs_n, lcd_sclk, lcd_si, lcd_a0}, 32'h8);
    chk_reg("midrst_status", 2'd1, 32'h0);
    chk_reg("midrst_ctrl", 2'd2, 32'h4);
    reset = 1'b0;
    m_div = 4; m_data = '0; m_ovr = 1'b0;
    repeat (2) @(negedge clk);
    chk_reg("postrst_status", 2'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
